// File: rtl/proc_rst_seq.sv
// Reset sequencer and run monitor for the processor core: stretches the board reset,
// releases the core, then latches a sticky failure on err (or watchdog, PROC_RST_SEQ_WDOG_EN).
module proc_rst_seq #(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_err,
    input  logic        i_commit,
    output logic        o_proc_rst,
    output logic        o_running,
    output logic        o_fail,
    output logic [1:0]  o_fail_cause,
    output logic [15:0] o_cyc_cnt
);

    localparam logic [7:0]  HoldLast = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {StHold, StRun, StFail} state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_hold_cnt, w_hold_cnt_d;
    logic        r_proc_rst, w_proc_rst_d;
    logic        r_running, w_running_d;
    logic        r_fail, w_fail_d;
    logic [1:0]  r_fail_cause, w_fail_cause_d;
    logic [15:0] r_cyc_cnt, w_cyc_cnt_d;
    logic [1:0]  w_cause;
    logic        w_wdog_to;

`ifdef PROC_RST_SEQ_WDOG_EN
    logic [15:0] r_wdog_cnt, w_wdog_cnt_d;
    assign w_wdog_to = r_running && !i_commit && (r_wdog_cnt == WdogLast);
`else
    logic w_unused;
    assign w_unused  = i_commit ^ WdogLast[0];
    assign w_wdog_to = 1'b0;
`endif

    // Monitoring starts once running is visible, so the core is never judged while in reset.
    assign w_cause = {w_wdog_to, r_running && i_err};

    always_comb begin
        w_state_d      = r_state;
        w_hold_cnt_d   = r_hold_cnt;
        w_proc_rst_d   = r_proc_rst;
        w_running_d    = r_running;
        w_fail_d       = r_fail;
        w_fail_cause_d = r_fail_cause;
        w_cyc_cnt_d    = r_cyc_cnt;
`ifdef PROC_RST_SEQ_WDOG_EN
        w_wdog_cnt_d   = r_wdog_cnt;
`endif
        unique case (r_state)
            StHold: begin
                w_hold_cnt_d = r_hold_cnt + 8'd1;
                w_proc_rst_d = 1'b1;
                w_running_d  = 1'b0;
                if (r_hold_cnt == HoldLast) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (r_running && (r_cyc_cnt != 16'hFFFF)) begin
                    w_cyc_cnt_d = r_cyc_cnt + 16'd1;
                end
`ifdef PROC_RST_SEQ_WDOG_EN
                if (r_running) begin
                    w_wdog_cnt_d = i_commit ? 16'd0 : r_wdog_cnt + 16'd1;
                end
`endif
                if (w_cause != 2'b00) begin
                    w_state_d      = StFail;
                    w_proc_rst_d   = 1'b1;
                    w_running_d    = 1'b0;
                    w_fail_d       = 1'b1;
                    w_fail_cause_d = w_cause;
                end else begin
                    w_proc_rst_d = 1'b0;
                    w_running_d  = 1'b1;
                end
            end
            StFail: begin
                w_proc_rst_d = 1'b1;
                w_running_d  = 1'b0;
            end
            default: begin
                w_state_d = StHold;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= StHold;
            r_hold_cnt   <= 8'd0;
            r_proc_rst   <= 1'b1;
            r_running    <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_cause <= 2'b00;
            r_cyc_cnt    <= 16'd0;
`ifdef PROC_RST_SEQ_WDOG_EN
            r_wdog_cnt   <= 16'd0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_hold_cnt   <= w_hold_cnt_d;
            r_proc_rst   <= w_proc_rst_d;
            r_running    <= w_running_d;
            r_fail       <= w_fail_d;
            r_fail_cause <= w_fail_cause_d;
            r_cyc_cnt    <= w_cyc_cnt_d;
`ifdef PROC_RST_SEQ_WDOG_EN
            r_wdog_cnt   <= w_wdog_cnt_d;
`endif
        end
    end

    assign o_proc_rst   = r_proc_rst;
    assign o_running    = r_running;
    assign o_fail       = r_fail;
    assign o_fail_cause = r_fail_cause;
    assign o_cyc_cnt    = r_cyc_cnt;

endmodule

// File: tb/tb_proc_rst_seq.sv
// Directed bench for proc_rst_seq: expectations queued per step and checked after each edge;
// a second instance with a 1-cycle hold exercises cyc_cnt saturation.
module tb_proc_rst_seq;

    logic        clk;
    logic        rst, err, commit;
    logic        proc_rst, running, fail;
    logic [1:0]  fail_cause;
    logic [15:0] cyc_cnt;

    logic        sat_rst;
    logic        sat_err, sat_commit;
    logic        sat_proc_rst, sat_running, sat_fail;
    logic [1:0]  sat_cause;
    logic [15:0] sat_cyc;

    typedef struct {
        string       tag;
        logic [20:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    int          cyc_total;
    int          sat_t0;
    logic [15:0] ecyc;
    logic [15:0] sat_prev;
    logic        sat_wrapped;

    proc_rst_seq #(.HOLD_CYCLES(8), .WDOG_CYCLES(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_err       (err),
        .i_commit    (commit),
        .o_proc_rst  (proc_rst),
        .o_running   (running),
        .o_fail      (fail),
        .o_fail_cause(fail_cause),
        .o_cyc_cnt   (cyc_cnt)
    );

    proc_rst_seq #(.HOLD_CYCLES(1), .WDOG_CYCLES(16)) dut_sat (
        .i_clk       (clk),
        .i_rst       (sat_rst),
        .i_err       (sat_err),
        .i_commit    (sat_commit),
        .o_proc_rst  (sat_proc_rst),
        .o_running   (sat_running),
        .o_fail      (sat_fail),
        .o_fail_cause(sat_cause),
        .o_cyc_cnt   (sat_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc_total++;
        if (sat_prev == 16'hFFFF && sat_cyc != 16'hFFFF) sat_wrapped = 1'b1;
        sat_prev = sat_cyc;
    endtask

    task automatic cycle_chk(input string tag, input logic pr, input logic run, input logic fl,
                             input logic [1:0] cs, input logic [15:0] cy);
        exp_t        e;
        logic [20:0] obs;
        e.tag = tag;
        e.val = {pr, run, fl, cs, cy};
        sb_q.push_back(e);
        tick();
        e   = sb_q.pop_front();
        obs = {proc_rst, running, fail, fail_cause, cyc_cnt};
        n_checks++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed={prst,run,fail,cause,cyc}=%h expected=%h",
                   e.tag, obs, e.val);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Eight cycles of core reset after E0, then the first RUN cycle with cyc_cnt = 0.
    task automatic hold_seq();
        for (int i = 0; i < 8; i++) cycle_chk("hold", 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        cycle_chk("run_start", 1'b0, 1'b1, 1'b0, 2'b00, 16'd0);
        ecyc = 16'd0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc_total   = 0;
        sat_prev    = 16'd0;
        sat_wrapped = 1'b0;
        rst         = 1'b0;
        err         = 1'b0;
        commit      = 1'b1;
        sat_rst     = 1'b0;
        sat_err     = 1'b0;
        sat_commit  = 1'b1;

        // Reset values, then the hold period and the start of counting.
        tick();
        tick();
        cycle_chk("reset", 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        rst     = 1'b1;
        sat_rst = 1'b1;
        sat_t0  = cyc_total;
        hold_seq();
        for (int i = 1; i <= 20; i++) begin
            ecyc++;
            cycle_chk("run_count", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
        end

        // Error trip at cyc_cnt = 20, then frozen while err/commit keep toggling.
        err = 1'b1;
        cycle_chk("err_trip", 1'b1, 1'b0, 1'b1, 2'b01, 16'd21);
        for (int i = 0; i < 50; i++) begin
            err    = (i % 3 == 0);
            commit = (i % 2 == 0);
            cycle_chk("fail_frozen", 1'b1, 1'b0, 1'b1, 2'b01, 16'd21);
        end
        err    = 1'b0;
        commit = 1'b1;

        // Single-cycle reset while in FAIL, then while in RUN.
        rst = 1'b0;
        cycle_chk("rst_in_fail", 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        rst = 1'b1;
        hold_seq();
        for (int i = 1; i <= 5; i++) begin
            ecyc++;
            cycle_chk("run_after_rst", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
        end
        rst = 1'b0;
        cycle_chk("rst_in_run", 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        rst = 1'b1;
        hold_seq();

        // Commit every 15 cycles, last one at t = 194; timeout lands at t = 210.
        for (int t = 0; t <= 210; t++) begin
            commit = (t <= 194) && (t % 15 == 14);
            ecyc++;
`ifdef PROC_RST_SEQ_WDOG_EN
            if (t == 210) cycle_chk("wdog_trip", 1'b1, 1'b0, 1'b1, 2'b10, ecyc);
            else cycle_chk("wdog_run", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
`else
            cycle_chk("nowdog_run", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
`endif
        end
        for (int i = 0; i < 5; i++) begin
`ifdef PROC_RST_SEQ_WDOG_EN
            cycle_chk("wdog_frozen", 1'b1, 1'b0, 1'b1, 2'b10, ecyc);
`else
            ecyc++;
            cycle_chk("nowdog_still", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
`endif
        end

        // err raised in the very cycle the watchdog would expire (no commits at all).
        rst    = 1'b0;
        commit = 1'b0;
        cycle_chk("rst_before_sim", 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        rst = 1'b1;
        hold_seq();
        for (int i = 1; i <= 15; i++) begin
            ecyc++;
            cycle_chk("sim_run", 1'b0, 1'b1, 1'b0, 2'b00, ecyc);
        end
        err = 1'b1;
`ifdef PROC_RST_SEQ_WDOG_EN
        cycle_chk("sim_causes", 1'b1, 1'b0, 1'b1, 2'b11, 16'd16);
`else
        cycle_chk("sim_causes", 1'b1, 1'b0, 1'b1, 2'b01, 16'd16);
`endif
        err = 1'b0;

        // Saturation instance: released alongside the main one, HOLD_CYCLES = 1.
        chk("sat_count", {16'd0, sat_cyc}, {16'd0, 16'(cyc_total - sat_t0 - 2)});
        while (cyc_total < 70100) tick();
        chk("sat_value", {16'd0, sat_cyc}, 32'h0000_FFFF);
        chk("sat_running", {29'd0, sat_running, sat_fail, sat_proc_rst}, 32'd4);
        chk("sat_no_wrap", {31'd0, sat_wrapped}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
